// File: rtl/chaos_keystream_ctrl.sv
// rtl/chaos_keystream_ctrl.sv - chaos generator sequencer, keystream word FIFO and byte XOR cipher
// Optional build macro KS_DISCARD_EN drops the first DISCARD iterations after each reseed.
module chaos_keystream_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int DISCARD    = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [31:0] SEED,
  output logic        BUSY,
  output logic        GEN_STEP,
  output logic        GEN_RESET,
  output logic [31:0] GEN_SHIFT,
  input  logic        GEN_DONE,
  input  logic [7:0]  GEN_CODE_X,
  input  logic [7:0]  GEN_CODE_Y,
  input  logic [7:0]  GEN_CODE_Z,
  input  logic [7:0]  GEN_CODE_W,
  input  logic [7:0]  DIN,
  input  logic        DIN_VALID,
  output logic        DIN_READY,
  output logic [7:0]  DOUT,
  output logic        DOUT_VALID,
  input  logic        DOUT_READY
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (DISCARD < 0) || (DISCARD > 255)) begin : g_param_check
    $error("chaos_keystream_ctrl: FIFO_DEPTH must be a power of two in 2..16, DISCARD in 0..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_CAPTURE,
    S_GAP,
    S_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   shift_q;
  logic [31:0]   code_q;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    byte_ptr_q;
  logic [7:0]    dout_q;
  logic          dout_valid_q;
  logic          busy_q;

  logic          keep_word;
  logic          fifo_empty, fifo_full;
  logic          fire, push, pop;
  logic [31:0]   head_word;
  logic [7:0]    head_byte;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign DIN_READY  = !fifo_empty && (!dout_valid_q || DOUT_READY) && (state_q != S_SEED);
  assign fire       = DIN_VALID && DIN_READY;
  assign pop        = fire && (byte_ptr_q == 2'd3);
  assign push       = (state_q == S_CAPTURE) && keep_word && (!fifo_full || pop);
  assign head_word  = mem_q[rd_ptr_q];
  assign count_d    = count_q + CW'(push) - CW'(pop);

  // Byte 0 of a word is the X code, so X is consumed first.
  always_comb begin
    head_byte = head_word[7:0];
    case (byte_ptr_q)
      2'd0:    head_byte = head_word[7:0];
      2'd1:    head_byte = head_word[15:8];
      2'd2:    head_byte = head_word[23:16];
      default: head_byte = head_word[31:24];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    GEN_STEP  = 1'b0;
    GEN_RESET = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_SEED: begin
        GEN_RESET = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        GEN_STEP = 1'b1;
        if (GEN_DONE) state_d = S_CAPTURE;
      end
      S_CAPTURE: state_d = S_GAP;
      S_GAP:     state_d = (count_q < DEPTH_C) ? S_RUN : S_HOLD;
      S_HOLD:    if (count_q < DEPTH_C) state_d = S_RUN;
      default:   state_d = S_IDLE;
    endcase
    if (START) state_d = S_SEED;
  end

`ifdef KS_DISCARD_EN
  logic [7:0] discard_q;

  assign keep_word = (discard_q >= 8'(DISCARD));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      discard_q <= '0;
    end else if (START) begin
      discard_q <= '0;
    end else if ((state_q == S_CAPTURE) && !keep_word) begin
      discard_q <= discard_q + 8'd1;
    end
  end
`else
  assign keep_word = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      code_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      byte_ptr_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_RUN) && GEN_DONE) begin
        code_q <= {GEN_CODE_W, GEN_CODE_Z, GEN_CODE_Y, GEN_CODE_X};
      end
      // START flushes everything downstream of the generator, including a pending DOUT.
      if (START) begin
        shift_q      <= SEED;
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        count_q      <= '0;
        byte_ptr_q   <= '0;
        dout_valid_q <= 1'b0;
        busy_q       <= 1'b1;
      end else begin
        count_q <= count_d;
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        if (fire) begin
          dout_q       <= DIN ^ head_byte;
          dout_valid_q <= 1'b1;
          byte_ptr_q   <= byte_ptr_q + 2'd1;
        end else if (DOUT_READY) begin
          dout_valid_q <= 1'b0;
        end
        if (push) busy_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !START) mem_q[wr_ptr_q] <= code_q;
  end

  assign BUSY       = busy_q;
  assign GEN_SHIFT  = shift_q;
  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;

endmodule

// File: doc/chaos_keystream_ctrl.md
Name: chaos_keystream_ctrl

Overview:
- Sits directly downstream of the chaos key generator. Sequences the generator's STEP/RESET/SHIFT protocol and captures each iteration's four code bytes into a word FIFO.
- Serialises the captured words into a byte keystream and XORs it onto a valid/ready byte stream, for encryption or decryption of pixel/data bytes.
- The Nios-side logic gives it a seed and a start request; the data path feeds it plaintext or ciphertext.

Parameters:
- FIFO_DEPTH, 4: keystream word FIFO depth, in 32-bit words. Power of two, 2..16.
- DISCARD, 16: number of warm-up iterations dropped after each reseed. Used only when KS_DISCARD_EN is defined.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse: reseed the generator with SEED and flush the keystream.
- SEED  in  32  IEEE-754 single-precision shift/scale value. Sampled on START.
- BUSY  out  1  high from START until the first keystream word is in the FIFO.
- GEN_STEP  out  1  drives the generator's STEP.
- GEN_RESET  out  1  drives the generator's RESET.
- GEN_SHIFT  out  32  drives the generator's SHIFT. Registered copy of SEED.
- GEN_DONE  in  1  generator iteration-complete flag.
- GEN_CODE_X, GEN_CODE_Y, GEN_CODE_Z, GEN_CODE_W  in  8 each  generator output bytes.
- DIN  in  8  input data byte.
- DIN_VALID  in  1  DIN is valid.
- DIN_READY  out  1  block accepts DIN this cycle.
- DOUT  out  8  DIN XOR keystream byte.
- DOUT_VALID  out  1  DOUT is valid.
- DOUT_READY  in  1  downstream accepts DOUT.

Behaviour:
- Reset (RESET_N low, asynchronous): all outputs 0 (including GEN_SHIFT), FIFO empty, byte pointer 0, state IDLE. Takes effect immediately, mid-iteration included.
- FSM states:
  - IDLE: GEN_STEP=0, GEN_RESET=0. Waits for START.
  - SEED: one cycle. GEN_RESET=1, GEN_STEP=0; generator returns to its initial-condition state.
  - RUN: GEN_STEP=1 until GEN_DONE samples 1.
  - CAPTURE: one cycle. GEN_STEP=0. Word {W,Z,Y,X} is pushed to the FIFO; byte X is consumed first.
  - GAP: one cycle. GEN_STEP=0, so the generator rearms for its next iteration.
  - HOLD: GEN_STEP=0 while the FIFO is full. Goes to RUN when a slot is free.
- Transitions:
  - IDLE --START--> SEED.
  - SEED --> RUN.
  - RUN --GEN_DONE--> CAPTURE.
  - CAPTURE --> GAP.
  - GAP --> RUN if the FIFO count after the push is below FIFO_DEPTH, else HOLD.
- START in any state: latch SEED into GEN_SHIFT, flush the FIFO, clear the byte pointer, drop any DOUT not yet accepted, assert BUSY, go to SEED. START has priority over every other event in that cycle.
- GEN_SHIFT is stable from SEED onward; the generator samples it on the first STEP cycle after reseed.
- Iteration length is set by the generator (about 52 cycles). The block never times out on GEN_DONE.
- Cipher path: DIN_READY = FIFO not empty AND (DOUT_VALID=0 OR DOUT_READY=1) AND state != SEED.
- On each DIN_VALID & DIN_READY:
  - DOUT <= DIN ^ byte[ptr] of the FIFO head; DOUT_VALID <= 1.
  - ptr advances 0→1→2→3; at 3 it wraps to 0 and the head word pops.
- DOUT_VALID clears on accept with no new input. Latency DIN to DOUT is 1 cycle. Throughput is 1 byte per cycle while keystream is available.
- Simultaneous pop (byte 3) and push (CAPTURE): both take effect; the FIFO count is unchanged.
- The FIFO is never written when full; RUN is entered only with a free slot.
- BUSY clears on the CAPTURE of the first kept word.

Optional Feature:
- KS_DISCARD_EN defined: after each SEED, the first DISCARD iterations run RUN/CAPTURE/GAP normally, but CAPTURE does not push. An 8-bit discard counter is cleared on START. BUSY stays high through the discard phase.
- KS_DISCARD_EN undefined: every iteration is pushed; no discard counter exists.

Test Plan:
- Reset, then START with SEED=0x447A0000. Stub generator asserts DONE 52 cycles after STEP rises, codes X=0x11, Y=0x22, Z=0x33, W=0x44. Required: GEN_RESET high exactly 1 cycle, GEN_SHIFT=0x447A0000, BUSY falls after the first CAPTURE, GEN_STEP low 2 cycles between iterations.
- Stream DIN=0x00,0x00,0x00,0x00 with DOUT_READY=1. Required: DOUT=0x11,0x22,0x33,0x44 on consecutive cycles, 1-cycle latency, then the next word follows.
- DOUT_READY=0 for 100+ cycles with no DIN. Required: the FIFO fills to FIFO_DEPTH, the FSM sits in HOLD with GEN_STEP=0, and exactly FIFO_DEPTH iterations occur.
- DOUT_READY held 0 with DOUT_VALID=1. Required: DOUT is stable, DIN_READY=0, no byte is lost or duplicated after release.
- START mid-RUN, and separately RESET_N low mid-RUN. Required: FIFO empty, GEN_STEP=0 the next cycle, a fresh SEED sequence, and all outputs 0 during reset.
- KS_DISCARD_EN with DISCARD=2, stub codes incrementing per iteration (0x01.., 0x02.., 0x03..). Required: the first keystream byte is 0x03.
